// File: rtl/zktc_uart_pkg.sv
// Shared UART constants and receiver FSM encoding for the zktc SoC.
// Build option UART_RX_PARITY_EN adds the PARITY state.
package zktc_uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received bytes; pointers carry one extra
// wrap bit so full/empty come from comparing the MSBs.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot in the same cycle, so a push while full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with FWFT byte buffer and framing/overrun pulses.
// Build option UART_RX_PARITY_EN: even parity bit, parity_err port.
//   state  | meaning
//   IDLE   | line idle, waiting for synchronised falling edge
//   START  | half a bit in, confirm start bit or reject glitch
//   DATA   | sample 8 data bits LSB first at bit centre
//   PARITY | sample parity bit (option only)
//   STOP   | sample stop bit, push or report, back to IDLE
module uart_rx
    import zktc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    logic                      rxd_meta_q;
    logic                      rxd_sync_q;
    rx_state_e                 state_q;
    logic [CW-1:0]             cnt_q;
    logic [BW-1:0]             bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      frame_err_q;
    logic                      overrun_q;
    logic                      par_bad;
    logic                      stop_tick;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;
    assign par_bad    = ^{shift_q, par_bit_q};
    assign parity_err = parity_err_q;
`else
    assign par_bad = 1'b0;
`endif

    // The push strobe is decoded in the sample cycle so the byte is visible next cycle.
    assign stop_tick = (state_q == RX_STOP) && (cnt_q == CNT_FULL);
    assign push      = stop_tick && rxd_sync_q && !par_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= push && fifo_full && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                RX_IDLE: begin
                    if (!rxd_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        state_q   <= rxd_sync_q ? RX_IDLE : RX_DATA;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_sync_q, shift_q[UART_DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q     <= '0;
                        par_bit_q <= rxd_sync_q;
                        state_q   <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (stop_tick) begin
                        cnt_q       <= '0;
                        state_q     <= RX_IDLE;
                        frame_err_q <= !rxd_sync_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (push),
        .wr_data_i (shift_q),
        .pop_i     (rx_ready),
        .rd_data_o (rx_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table plus hand-written corner sequences,
// received bytes checked against a scoreboard queue.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_EDGE = 171;
`else
    localparam int STOP_EDGE = 155;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] sb_q[$];
    int n_cmp   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_perr  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid && rx_ready) begin
                n_valid++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected got=%02h want=none", rx_data);
                end else begin
                    check("sb_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
                end
            end
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) n_perr++;
`endif
        end
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_v);
        rxd = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_v, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par_v);
        drive_bit(stop_v);
        rxd = 1'b1;
    endtask
`endif

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, f0, o0, p0;
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h55, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h81, 1'b0, 0, 1};

        rxd = 1'b1; rx_ready = 1'b1; rstn = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame with exact latency from the start-bit edge
        v0 = n_valid; f0 = n_ferr;
        sb_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                check("lat_before", {31'd0, rx_valid}, 32'd0);
                @(negedge clk);
                check("lat_valid", {31'd0, rx_valid}, 32'd1);
                check("lat_data", {24'd0, rx_data}, 32'hA5);
            end
        join
        repeat (20) @(negedge clk);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_ferr_cnt", n_ferr - f0, 0);

        for (int k = 0; k < 6; k++) begin
            v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
            if (vecs[k].exp_valid != 0) sb_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, vecs[k].stop);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr", k), n_ovr - o0, 0);
        end
        check("tbl_sb_empty", sb_q.size(), 0);

        // Glitch on idle line
        v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_ovr", n_ovr - o0, 0);

        // Overrun with FIFO_DEPTH = 4
        rx_ready = 1'b0;
        v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) sb_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        repeat (5) @(negedge clk);
        check("ovr_cnt", n_ovr - o0, 1);
        check("ovr_ferr", n_ferr - f0, 0);
        check("ovr_head", {24'd0, rx_data}, 32'h01);
        check("ovr_full_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        for (int c = 0; c < 50 && sb_q.size() != 0; c++) @(negedge clk);
        check("ovr_drain", sb_q.size(), 0);
        check("ovr_valid_cnt", n_valid - v0, 4);
        @(negedge clk);
        check("ovr_empty", {31'd0, rx_valid}, 32'd0);

        // Reset during DATA bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (CPB * 10) @(negedge clk);
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_data", {24'd0, rx_data}, 32'd0);
        v0 = n_valid; f0 = n_ferr;
        sb_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        check("post_rst_valid", n_valid - v0, 1);
        check("post_rst_ferr", n_ferr - f0, 0);

`ifdef UART_RX_PARITY_EN
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame_par(8'h07, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("par_bad_perr", n_perr - p0, 1);
        check("par_bad_valid", n_valid - v0, 0);
        check("par_bad_ferr", n_ferr - f0, 0);
        v0 = n_valid; p0 = n_perr;
        sb_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("par_ok_valid", n_valid - v0, 1);
        check("par_ok_perr", n_perr - p0, 0);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame_par(8'h07, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("par_both_perr", n_perr - p0, 1);
        check("par_both_ferr", n_ferr - f0, 1);
        check("par_both_valid", n_valid - v0, 0);
`else
        p0 = n_perr;
        check("no_parity_perr", n_perr - p0, 0);
`endif

        check("final_sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
